ex_div: RTL and testbench

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div.sv | 150 +++++++++++++++
 tb/tb_ex_div.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_div.sv
// rtl/ex_div.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  reg_waddr_i,
    output logic [31:0] result_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [4:0]  reg_waddr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_CALC,
        S_END
    } state_t;

    state_t      r_state;
    logic        r_is_unsigned;
    logic        r_is_rem;
    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [31:0] r_divisor_abs;
    logic [4:0]  r_waddr;
    logic [5:0]  r_count;
    logic [63:0] r_work;

    logic        w_unused_op;
    logic        w_dividend_neg;
    logic        w_divisor_neg;
    logic [31:0] w_dividend_abs;
    logic [31:0] w_divisor_abs;
    logic        w_div_zero;
    logic        w_overflow;
    logic [31:0] w_fast_result;
    logic [32:0] w_trial;
    logic [63:0] w_work_next;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_calc_result;

    // funct3[2] is always 1 for the divide group, so only the low two bits select the op
    assign w_unused_op    = op_i[2];

    assign w_dividend_neg = !r_is_unsigned && r_dividend[31];
    assign w_divisor_neg  = !r_is_unsigned && r_divisor[31];
    assign w_dividend_abs = w_dividend_neg ? (32'd0 - r_dividend) : r_dividend;
    assign w_divisor_abs  = w_divisor_neg  ? (32'd0 - r_divisor)  : r_divisor;

    assign w_div_zero = (r_divisor == 32'd0);
    assign w_overflow = !r_is_unsigned && (r_dividend == 32'h8000_0000)
                        && (r_divisor == 32'hFFFF_FFFF);

    assign w_fast_result = w_div_zero ? (r_is_rem ? r_dividend : 32'hFFFF_FFFF)
                                      : (r_is_rem ? 32'd0 : 32'h8000_0000);

    // Partial remainder can reach 33 bits after the shift, so the trial subtract is 33 wide
    assign w_trial     = r_work[63:31] - {1'b0, r_divisor_abs};
    assign w_work_next = w_trial[32] ? {r_work[62:0], 1'b0}
                                     : {w_trial[31:0], r_work[30:0], 1'b1};

    assign w_quot = (w_dividend_neg ^ w_divisor_neg) ? (32'd0 - w_work_next[31:0])
                                                     : w_work_next[31:0];
    assign w_rem  = w_dividend_neg ? (32'd0 - w_work_next[63:32]) : w_work_next[63:32];
    assign w_calc_result = r_is_rem ? w_rem : w_quot;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_is_unsigned <= 1'b0;
            r_is_rem      <= 1'b0;
            r_dividend    <= 32'd0;
            r_divisor     <= 32'd0;
            r_divisor_abs <= 32'd0;
            r_waddr       <= 5'd0;
            r_count       <= 6'd0;
            r_work        <= 64'd0;
            result_o      <= 32'd0;
            ready_o       <= 1'b0;
            busy_o        <= 1'b0;
            reg_waddr_o   <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready_o     <= 1'b0;
                    result_o    <= 32'd0;
                    reg_waddr_o <= 5'd0;
                    if (start_i) begin
                        r_is_unsigned <= op_i[0];
                        r_is_rem      <= op_i[1];
                        r_dividend    <= dividend_i;
                        r_divisor     <= divisor_i;
                        r_waddr       <= reg_waddr_i;
                        busy_o        <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    if (!start_i) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_div_zero || w_overflow) begin
                        ready_o     <= 1'b1;
                        result_o    <= w_fast_result;
                        reg_waddr_o <= r_waddr;
                        r_state     <= S_END;
                    end else begin
                        r_count       <= 6'd0;
                        r_work        <= {32'd0, w_dividend_abs};
                        r_divisor_abs <= w_divisor_abs;
                        r_state       <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (!start_i) begin
                        busy_o  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_work  <= w_work_next;
                        r_count <= r_count + 6'd1;
                        // Last step: publish the sign-corrected result directly
                        if (r_count == 6'd31) begin
                            ready_o     <= 1'b1;
                            result_o    <= w_calc_result;
                            reg_waddr_o <= r_waddr;
                            r_state     <= S_END;
                        end
                    end
                end
                S_END: begin
                    ready_o     <= 1'b0;
                    result_o    <= 32'd0;
                    reg_waddr_o <= 5'd0;
                    busy_o      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// tb/tb_ex_div.sv - self-checking bench for ex_div
module tb_ex_div;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] dividend_i = 32'd0;
    logic [31:0] divisor_i = 32'd0;
    logic [4:0]  reg_waddr_i = 5'd0;
    logic [31:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic [4:0]  reg_waddr_o;

    int checks = 0;
    int errors = 0;

    localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

    ex_div dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .reg_waddr_i (reg_waddr_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o),
        .reg_waddr_o (reg_waddr_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics from plain integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wa,
                          input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic quiet;
        start_i     = 1'b1;
        op_i        = op;
        dividend_i  = a;
        divisor_i   = b;
        reg_waddr_i = wa;
        @(posedge clk);
        #1;
        check({name, ".busy"}, {31'd0, busy_o}, 32'd1);
        lat   = 0;
        quiet = 1'b1;
        while (!ready_o && lat < 40) begin
            if (result_o != 32'd0 || reg_waddr_o != 5'd0) quiet = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, ".quiet"}, {31'd0, quiet}, 32'd1);
        check({name, ".latency"}, 32'(lat), 32'(exp_lat));
        check({name, ".result"}, result_o, exp);
        check({name, ".waddr"}, {27'd0, reg_waddr_o}, {27'd0, wa});
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check({name, ".after"}, {ready_o, busy_o, result_o[29:0]}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33};
        vecs[1]  = '{OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33};
        vecs[2]  = '{OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33};
        vecs[3]  = '{OP_DIVU, 32'd5, 32'd0, 5'd3, 32'hFFFF_FFFF, 1};
        vecs[4]  = '{OP_REMU, 32'd5, 32'd0, 5'd4, 32'd5, 1};
        vecs[5]  = '{OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h8000_0000, 1};
        vecs[6]  = '{OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'd0, 1};
        vecs[7]  = '{OP_DIV, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1};
        vecs[8]  = '{OP_REM, 32'hFFFF_FFFB, 32'd0, 5'd9, 32'hFFFF_FFFB, 1};
        vecs[9]  = '{OP_REMU, 32'hFFFF_FFFF, 32'd10, 5'd10, 32'd5, 33};
        vecs[10] = '{OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 33};
        vecs[11] = '{OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33};
        vecs[12] = '{OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, 33};
        vecs[13] = '{OP_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd14, 32'd3, 33};
        vecs[14] = '{OP_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, 33};
        vecs[15] = '{OP_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd31, 32'hFFFF_FFFF, 33};

        repeat (2) @(posedge clk);
        #1;
        check("reset.outputs", {ready_o, busy_o, 25'd0, reg_waddr_o}, 32'd0);
        check("reset.result", result_o, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa,
                   vecs[i].exp, vecs[i].lat);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            int          sel;
            op  = 3'(4 + $urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel < 2) b = 32'd0;
            else if (sel < 5) b = 32'($urandom_range(1, 300));
            else if (sel == 5) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 6) b = b >> $urandom_range(1, 31);
            run_op($sformatf("rand%0d", i), op, a, b, 5'($urandom_range(0, 31)),
                   ref_result(op, a, b), ref_latency(op, a, b));
        end

        // Abort ten cycles into CALC
        begin
            logic seen;
            start_i     = 1'b1;
            op_i        = OP_DIVU;
            dividend_i  = 32'd123456;
            divisor_i   = 32'd77;
            reg_waddr_i = 5'd9;
            @(posedge clk);
            repeat (11) @(posedge clk);
            #1;
            start_i = 1'b0;
            @(posedge clk);
            #1;
            check("abort.busy", {31'd0, busy_o}, 32'd0);
            seen = ready_o;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (ready_o) seen = 1'b1;
            end
            check("abort.no_ready", {31'd0, seen}, 32'd0);
            run_op("abort.next", OP_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, 33);
        end

        // Asynchronous reset mid-CALC
        begin
            logic seen;
            start_i     = 1'b1;
            op_i        = OP_DIV;
            dividend_i  = 32'hFFFF_0000;
            divisor_i   = 32'd3;
            reg_waddr_i = 5'd17;
            @(posedge clk);
            repeat (10) @(posedge clk);
            #3;
            check("areset.busy_before", {31'd0, busy_o}, 32'd1);
            rst     = 1'b0;
            start_i = 1'b0;
            #1;
            check("areset.outputs", {ready_o, busy_o, 25'd0, reg_waddr_o}, 32'd0);
            check("areset.result", result_o, 32'd0);
            @(posedge clk);
            #1;
            rst  = 1'b1;
            seen = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (ready_o || busy_o) seen = 1'b1;
            end
            check("areset.no_ready", {31'd0, seen}, 32'd0);
            run_op("areset.next", OP_REM, 32'd100, 32'hFFFF_FFF9, 5'd20, 32'd2, 33);
        end

        // Reset while the fast-path result is presented must clear it at once
        begin
            start_i     = 1'b1;
            op_i        = OP_REMU;
            dividend_i  = 32'hDEAD_BEEF;
            divisor_i   = 32'd0;
            reg_waddr_i = 5'd21;
            @(posedge clk);
            @(posedge clk);
            #1;
            check("areset_end.result_before", result_o, 32'hDEAD_BEEF);
            #2;
            rst     = 1'b0;
            start_i = 1'b0;
            #1;
            check("areset_end.result", result_o, 32'd0);
            check("areset_end.flags", {ready_o, busy_o, 25'd0, reg_waddr_o}, 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
